// File: rtl/systolic_gemm.sv
// Output-stationary systolic GEMM (Y = A*B) with internal operand skew.
// Define SYSTOLIC_SAT_EN for saturating accumulation with a sticky ovf flag.
module systolic_gemm #(
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [$clog2(N+1)-1:0]        len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH*M-1:0]       x_in,
    input  logic [DATA_WIDTH*K-1:0]       w_in,
    output logic                          busy,
    output logic                          y_valid,
    input  logic                          y_ready,
    output logic [ACC_WIDTH*M*K-1:0]      y_out,
    output logic                          ovf
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int LW = $clog2(N+1);
    localparam int CW = $clog2(N+M+K);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d, len_c;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            clr, step;

    logic [DW-1:0]   xd_q [M][M];
    logic [DW-1:0]   xd_d [M][M];
    logic [DW-1:0]   xt   [M][M];
    logic [DW-1:0]   wd_q [K][K];
    logic [DW-1:0]   wd_d [K][K];
    logic [DW-1:0]   wt   [K][K];
    logic [DW-1:0]   xp_q [M][K];
    logic [DW-1:0]   xp_d [M][K];
    logic [DW-1:0]   wp_q [M][K];
    logic [DW-1:0]   wp_d [M][K];
    logic [DW-1:0]   xa   [M][K];
    logic [DW-1:0]   wa   [M][K];
    logic [AW-1:0]   acc_q [M][K];
    logic [AW-1:0]   acc_d [M][K];

    logic signed [2*DW-1:0] prod [M][K];
    logic signed [AW-1:0]   ext  [M][K];
`ifdef SYSTOLIC_SAT_EN
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    logic [AW:0]   sum [M][K];
`else
    logic [AW-1:0] sum [M][K];
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        step    = 1'b0;
        len_c   = (len > LW'(N)) ? LW'(N) : len;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    len_d   = len_c;
                    cnt_d   = '0;
                    state_d = (len_c == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    step = 1'b1;
                    if (cnt_q == CW'(len_q) - CW'(1)) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                step = 1'b1;
                if (cnt_q == CW'(M+K-2)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (y_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tap n of a skew line holds the operand injected n steps ago.
    always_comb begin
        xt = xd_q;
        wt = wd_q;
        xa = xp_q;
        wa = wp_q;
        for (int i = 0; i < M; i++) begin
            xt[i][0] = (state_q == S_LOAD) ? x_in[DW*i +: DW] : '0;
        end
        for (int j = 0; j < K; j++) begin
            wt[j][0] = (state_q == S_LOAD) ? w_in[DW*j +: DW] : '0;
        end
        for (int i = 0; i < M; i++) begin
            xa[i][0] = xt[i][i];
            for (int j = 1; j < K; j++) xa[i][j] = xp_q[i][j-1];
        end
        for (int j = 0; j < K; j++) begin
            wa[0][j] = wt[j][j];
            for (int i = 1; i < M; i++) wa[i][j] = wp_q[i-1][j];
        end
    end

    always_comb begin
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < K; j++) begin
                prod[i][j] = (2*DW)'($signed(xa[i][j]))
                           * (2*DW)'($signed(wa[i][j]));
                ext[i][j]  = AW'(prod[i][j]);
`ifdef SYSTOLIC_SAT_EN
                sum[i][j]  = {acc_q[i][j][AW-1], acc_q[i][j]}
                           + {ext[i][j][AW-1], ext[i][j]};
`else
                sum[i][j]  = acc_q[i][j] + ext[i][j];
`endif
            end
        end
    end

    always_comb begin
        xd_d  = xd_q;
        wd_d  = wd_q;
        xp_d  = xp_q;
        wp_d  = wp_q;
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr) begin
            ovf_d = 1'b0;
            for (int i = 0; i < M; i++)
                for (int n = 0; n < M; n++) xd_d[i][n] = '0;
            for (int j = 0; j < K; j++)
                for (int n = 0; n < K; n++) wd_d[j][n] = '0;
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < K; j++) begin
                    xp_d[i][j]  = '0;
                    wp_d[i][j]  = '0;
                    acc_d[i][j] = '0;
                end
            end
        end else if (step) begin
            for (int i = 0; i < M; i++)
                for (int n = 1; n < M; n++) xd_d[i][n] = xt[i][n-1];
            for (int j = 0; j < K; j++)
                for (int n = 1; n < K; n++) wd_d[j][n] = wt[j][n-1];
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < K; j++) begin
                    xp_d[i][j] = xa[i][j];
                    wp_d[i][j] = wa[i][j];
`ifdef SYSTOLIC_SAT_EN
                    if (sum[i][j][AW] != sum[i][j][AW-1]) begin
                        acc_d[i][j] = sum[i][j][AW] ? ACC_MIN : ACC_MAX;
                        ovf_d       = 1'b1;
                    end else begin
                        acc_d[i][j] = sum[i][j][AW-1:0];
                    end
`else
                    acc_d[i][j] = sum[i][j];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < M; i++)
                for (int n = 0; n < M; n++) xd_q[i][n] <= '0;
            for (int j = 0; j < K; j++)
                for (int n = 0; n < K; n++) wd_q[j][n] <= '0;
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < K; j++) begin
                    xp_q[i][j]  <= '0;
                    wp_q[i][j]  <= '0;
                    acc_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            xd_q    <= xd_d;
            wd_q    <= wd_d;
            xp_q    <= xp_d;
            wp_q    <= wp_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);
    assign y_valid  = (state_q == S_DONE);
    assign ovf      = ovf_q;

    always_comb begin
        y_out = '0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < K; j++)
                y_out[AW*(i*K+j) +: AW] = acc_q[i][j];
    end

endmodule

// File: tb/tb_systolic_gemm.sv
// Self-checking bench for systolic_gemm: vector table, scoreboard queue,
// plus hand-written reset, zero-depth hold and saturation sequences.
module tb_systolic_gemm;

    localparam int M    = 4;
    localparam int K    = 4;
    localparam int N    = 8;
    localparam int DW   = 16;
    localparam int AW   = 40;
    localparam int YW   = AW*M*K;
    localparam int Y32W = 32*M*K;

`ifdef SYSTOLIC_SAT_EN
    localparam longint EXP32    = 64'h7FFF_FFFF;
    localparam logic   EXP_OVF32 = 1'b1;
`else
    localparam longint EXP32    = 64'h0;
    localparam logic   EXP_OVF32 = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [3:0]      len;
    logic            in_valid;
    logic            in_ready, in_ready32;
    logic [DW*M-1:0] x_in;
    logic [DW*K-1:0] w_in;
    logic            busy, busy32;
    logic            y_valid, y_valid32;
    logic            y_ready;
    logic [YW-1:0]   y_out;
    logic [Y32W-1:0] y_out32;
    logic            ovf, ovf32;

    systolic_gemm #(
        .M(M), .K(K), .N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .w_in(w_in), .busy(busy),
        .y_valid(y_valid), .y_ready(y_ready),
        .y_out(y_out), .ovf(ovf)
    );

    systolic_gemm #(
        .M(M), .K(K), .N(N), .DATA_WIDTH(DW), .ACC_WIDTH(32)
    ) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready32),
        .x_in(x_in), .w_in(w_in), .busy(busy32),
        .y_valid(y_valid32), .y_ready(y_ready),
        .y_out(y_out32), .ovf(ovf32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [YW-1:0] y;
        int            lat;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int     len;
        int     xv;
        int     wv;
        bit     bub;
        longint y;
        int     lat;
        bit     chk32;
    } vec_t;

    task automatic chk(input string nm, input logic [YW-1:0] act,
                       input logic [YW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [YW-1:0] fill(input longint v);
        logic [63:0] t;
        t = v;
        fill = '0;
        for (int c = 0; c < M*K; c++) fill[AW*c +: AW] = t[AW-1:0];
    endfunction

    function automatic logic [Y32W-1:0] fill32(input longint v);
        logic [63:0] t;
        t = v;
        fill32 = '0;
        for (int c = 0; c < M*K; c++) fill32[32*c +: 32] = t[31:0];
    endfunction

    function automatic logic [YW-1:0] ident_y();
        ident_y = '0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < K; j++)
                ident_y[AW*(i*K+j) +: AW] = AW'(4*i+j+1);
    endfunction

    // mode 0: uniform operands, mode 1: A = I, B[k][j] = 4k+j+1
    task automatic set_ops(input int mode, input int k,
                           input int xv, input int wv);
        for (int i = 0; i < M; i++)
            x_in[DW*i +: DW] = (mode == 1) ?
                ((i == k) ? 16'd1 : 16'd0) : DW'(xv);
        for (int j = 0; j < K; j++)
            w_in[DW*j +: DW] = (mode == 1) ? DW'(4*k+j+1) : DW'(wv);
    endtask

    task automatic run_job(input int l, input int mode, input int xv,
                           input int wv, input bit bub,
                           input logic [YW-1:0] yexp, input int lat,
                           input int hold, input string nm);
        exp_t e;
        int   cyc;
        int   beats;
        int   phase;
        bit   done;
        e.y   = yexp;
        e.lat = lat;
        sbq.push_back(e);
        start = 1'b1;
        len   = 4'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        beats = 0;
        phase = 0;
        done  = 1'b0;
        while (!done && cyc < 300) begin
            if (y_valid) begin
                done = 1'b1;
            end else begin
                if (in_ready) begin
                    in_valid = !(bub && phase[0]);
                    set_ops(mode, beats, xv, wv);
                    phase++;
                    if (in_valid) beats++;
                end else begin
                    in_valid = 1'b0;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        in_valid = 1'b0;
        if (!done || sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got=%0d want=%0d", nm, cyc, lat);
            if (sbq.size() > 0) e = sbq.pop_front();
        end else begin
            e = sbq.pop_front();
            chk({nm, "_lat"}, YW'(cyc), YW'(e.lat));
            chk({nm, "_y"}, y_out, e.y);
            chk({nm, "_ovf"}, YW'(ovf), YW'(0));
            for (int h = 0; h < hold; h++) begin
                start = 1'b1;
                len   = 4'd3;
                @(posedge clk);
                #1;
                chk({nm, "_hold_vld"}, YW'(y_valid), YW'(1));
                chk({nm, "_hold_y"}, y_out, e.y);
            end
            start   = 1'b0;
            y_ready = 1'b1;
            @(posedge clk);
            #1;
            y_ready = 1'b0;
            chk({nm, "_release"}, YW'({y_valid, busy}), YW'(0));
        end
    endtask

    vec_t vec [6];

    initial begin
        vec[0] = '{3, 1, 1, 1'b1, 64'sd3, 13, 1'b0};
        vec[1] = '{8, -3, 7, 1'b0, -64'sd168, 16, 1'b0};
        vec[2] = '{5, 2, -5, 1'b1, -64'sd50, 17, 1'b0};
        vec[3] = '{12, 1, 1, 1'b0, 64'sd8, 16, 1'b0};
        vec[4] = '{8, 32767, 32767, 1'b0, 64'sd8589410312, 16, 1'b0};
        vec[5] = '{8, -32768, -32768, 1'b0, 64'sd8589934592, 16, 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        x_in     = '0;
        w_in     = '0;
        y_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", YW'({in_ready, busy, y_valid, ovf}), YW'(0));
        chk("rst_y", y_out, '0);
        chk("rst_y32", YW'(y_out32), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            run_job(vec[v].len, 0, vec[v].xv, vec[v].wv, vec[v].bub,
                    fill(vec[v].y), vec[v].lat, 0, $sformatf("vec%0d", v));
            if (vec[v].chk32) begin
                chk("sat32_y", YW'(y_out32), YW'(fill32(EXP32)));
                chk("sat32_ovf", YW'(ovf32), YW'(EXP_OVF32));
            end
        end

        run_job(4, 1, 0, 0, 1'b0, ident_y(), 12, 0, "ident");
        run_job(0, 0, 0, 0, 1'b0, fill(0), 1, 5, "zero");
        run_job(2, 0, 3, 4, 1'b0, fill(24), 10, 0, "b2b");

        start = 1'b1;
        len   = 4'd4;
        set_ops(0, 0, 1, 1);
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("midload_busy", YW'({busy, in_ready}), YW'(3));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_flags", YW'({in_ready, busy, y_valid, ovf}), YW'(0));
        chk("midrst_y", y_out, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_job(1, 0, 2, 2, 1'b0, fill(4), 9, 0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
